// File: rtl/qu_pkg.sv
// Shared Qu front-end types and defaults.
// Redirect controller state encoding.
package qu_pkg;

  localparam int unsigned QU_PC_WIDTH  = 32;
  localparam int unsigned QU_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    RUN,
    FLUSH,
    LOAD,
    START_IF,
    START_ID,
    WAIT_RN
  } redirect_state_t;

endpackage

// File: rtl/redirect_ctrl_if.sv
// Redirect controller bus: startup enables, redirect request,
// FIFO status in; gated enables, flushes, PC load, stats out.
interface redirect_ctrl_if #(
  parameter int unsigned PC_WIDTH  = qu_pkg::QU_PC_WIDTH,
  parameter int unsigned CNT_WIDTH = qu_pkg::QU_CNT_WIDTH
);

  logic                 if_en_i;
  logic                 id_en_i;
  logic                 rn_en_i;
  logic                 redirect_valid;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic                 fifo_mp_rn_empty;

  logic                 if_en;
  logic                 id_en;
  logic                 rn_en;
  logic                 if_flush;
  logic                 id_flush;
  logic                 rn_flush;
  logic                 fifo_flush;
  logic                 pc_load;
  logic [PC_WIDTH-1:0]  pc_load_value;
  logic                 busy;
  logic [CNT_WIDTH-1:0] redirect_count;

  modport master (
    output if_en_i, id_en_i, rn_en_i,
    output redirect_valid, redirect_pc,
    output fifo_mp_rn_empty,
    input  if_en, id_en, rn_en,
    input  if_flush, id_flush, rn_flush, fifo_flush,
    input  pc_load, pc_load_value,
    input  busy, redirect_count
  );

  modport slave (
    input  if_en_i, id_en_i, rn_en_i,
    input  redirect_valid, redirect_pc,
    input  fifo_mp_rn_empty,
    output if_en, id_en, rn_en,
    output if_flush, id_flush, rn_flush, fifo_flush,
    output pc_load, pc_load_value,
    output busy, redirect_count
  );

endinterface

// File: rtl/redirect_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones.
// Used for the redirect statistics count.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/redirect_ctrl.sv
// Front-end redirect controller: flush IF/ID/RN and the uop FIFO,
// load the new PC, then re-enable IF, ID, RN in boot order.
module redirect_ctrl
  import qu_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = QU_PC_WIDTH,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = QU_CNT_WIDTH
) (
  input logic            clk,
  input logic            rst,
  redirect_ctrl_if.slave bus
);

  localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] FC_LOAD = FCW'(FLUSH_CYCLES - 1);

  redirect_state_t     state_q;
  redirect_state_t     state_d;
  logic [FCW-1:0]      fcnt_q;
  logic [FCW-1:0]      fcnt_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  logic gate_if;
  logic gate_id;
  logic gate_rn;
  logic flush;
  logic load;

  // Next state: any redirect restarts the flush with the newest PC.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_d    = pc_q;
    if (bus.redirect_valid) begin
      state_d = FLUSH;
      fcnt_d  = FC_LOAD;
      pc_d    = bus.redirect_pc;
    end else begin
      unique case (state_q)
        RUN: ;
        FLUSH: begin
          if (fcnt_q == '0) begin
            state_d = LOAD;
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
        LOAD:     state_d = START_IF;
        START_IF: state_d = START_ID;
        START_ID: state_d = WAIT_RN;
        WAIT_RN: begin
          if (!bus.fifo_mp_rn_empty) begin
            state_d = RUN;
          end
        end
        default:  state_d = RUN;
      endcase
    end
  end

  // State, flush counter and captured PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
    end
  end

  // Moore decode of gates, flush and PC load.
  always_comb begin
    gate_if = 1'b0;
    gate_id = 1'b0;
    gate_rn = 1'b0;
    flush   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      RUN: begin
        gate_if = 1'b1;
        gate_id = 1'b1;
        gate_rn = 1'b1;
      end
      FLUSH:    flush = 1'b1;
      LOAD:     load = 1'b1;
      START_IF: gate_if = 1'b1;
      START_ID, WAIT_RN: begin
        gate_if = 1'b1;
        gate_id = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.if_en = bus.if_en_i & gate_if & ~rst;
  assign bus.id_en = bus.id_en_i & gate_id & ~rst;
  assign bus.rn_en = bus.rn_en_i & gate_rn & ~rst;

  assign bus.if_flush   = flush;
  assign bus.id_flush   = flush;
  assign bus.rn_flush   = flush;
  assign bus.fifo_flush = flush;

  assign bus.pc_load       = load;
  assign bus.pc_load_value = load ? pc_q : '0;
  assign bus.busy          = (state_q != RUN);

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (bus.redirect_valid),
    .count_o (bus.redirect_count)
  );

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: cycle-timing reference model,
// directed scenarios then random traffic.
module tb_redirect_ctrl;

  localparam int FC = 2;

  typedef struct packed {
    logic        if_en;
    logic        id_en;
    logic        rn_en;
    logic        if_fl;
    logic        id_fl;
    logic        rn_fl;
    logic        ff_fl;
    logic        pc_load;
    logic [31:0] pcv;
    logic        busy;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  redirect_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) bus ();
  redirect_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

  assign bus2.if_en_i          = bus.if_en_i;
  assign bus2.id_en_i          = bus.id_en_i;
  assign bus2.rn_en_i          = bus.rn_en_i;
  assign bus2.redirect_valid   = bus.redirect_valid;
  assign bus2.redirect_pc      = bus.redirect_pc;
  assign bus2.fifo_mp_rn_empty = bus.fifo_mp_rn_empty;

  redirect_ctrl #(
    .PC_WIDTH(32), .FLUSH_CYCLES(FC), .CNT_WIDTH(16)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  redirect_ctrl #(
    .PC_WIDTH(32), .FLUSH_CYCLES(FC), .CNT_WIDTH(2)
  ) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position k within the redirect timeline.
  bit          active = 0;
  int          k = 0;
  logic [31:0] mpc = '0;
  int          nred = 0;

  task automatic cyc(input bit r, input bit rv, input logic [31:0] p,
                     input bit fe, input bit e_if, input bit e_id,
                     input bit e_rn);
    obs_t e;
    bit gif, gid, grn;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.redirect_valid   = rv;
    bus.redirect_pc      = p;
    bus.fifo_mp_rn_empty = fe;
    bus.if_en_i          = e_if;
    bus.id_en_i          = e_id;
    bus.rn_en_i          = e_rn;
    if (r) begin
      active = 0;
      k      = 0;
      mpc    = '0;
      nred   = 0;
      e      = '0;
    end else begin
      gif       = !active || (k >= FC + 2);
      gid       = !active || (k >= FC + 3);
      grn       = !active;
      e         = '0;
      e.if_en   = e_if & gif;
      e.id_en   = e_id & gid;
      e.rn_en   = e_rn & grn;
      e.if_fl   = active && (k <= FC);
      e.id_fl   = e.if_fl;
      e.rn_fl   = e.if_fl;
      e.ff_fl   = e.if_fl;
      e.pc_load = active && (k == FC + 1);
      e.pcv     = e.pc_load ? mpc : 32'h0;
      e.busy    = active;
      e.cnt     = (nred > 65535) ? 16'hffff : 16'(nred);
      e.cnt2    = (nred > 3) ? 2'd3 : 2'(nred);
    end
    exp_q.push_back(e);
    if (!r) begin
      if (rv) begin
        active = 1;
        k      = 1;
        mpc    = p;
        nred++;
      end else if (active) begin
        if (k >= FC + 4 && !fe) active = 0;
        else k++;
      end
    end
  endtask

  task automatic idle(input int n, input bit fe);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, fe, 1, 1, 1);
  endtask

  // Monitor: compare every cycle the DUT presents outputs.
  always @(negedge clk) begin
    obs_t e;
    obs_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g.if_en   = bus.if_en;
      g.id_en   = bus.id_en;
      g.rn_en   = bus.rn_en;
      g.if_fl   = bus.if_flush;
      g.id_fl   = bus.id_flush;
      g.rn_fl   = bus.rn_flush;
      g.ff_fl   = bus.fifo_flush;
      g.pc_load = bus.pc_load;
      g.pcv     = bus.pc_load_value;
      g.busy    = bus.busy;
      g.cnt     = bus.redirect_count;
      g.cnt2    = bus2.redirect_count;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got=%h required=%h", $time, g, e);
      end
    end
  end

  initial begin
    bus.redirect_valid   = 0;
    bus.redirect_pc      = '0;
    bus.fifo_mp_rn_empty = 1;
    bus.if_en_i          = 1;
    bus.id_en_i          = 1;
    bus.rn_en_i          = 1;

    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0, 1, 1, 1, 1);
    idle(3, 1);

    // Single redirect; FIFO refills at N+6.
    cyc(0, 1, 32'h0000_1000, 1, 1, 1, 1);
    idle(5, 1);
    idle(3, 0);

    // Redirect during FLUSH.
    cyc(0, 1, 32'h100, 1, 1, 1, 1);
    cyc(0, 1, 32'h200, 1, 1, 1, 1);
    idle(9, 0);

    // Redirect coinciding with LOAD.
    cyc(0, 1, 32'h300, 1, 1, 1, 1);
    idle(2, 1);
    cyc(0, 1, 32'h400, 1, 1, 1, 1);
    idle(9, 0);

    // ID startup enable held low.
    cyc(0, 1, 32'h500, 1, 1, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 32'h0, i < 6, 1, 0, 1);

    // Reset asserted in WAIT_RN.
    cyc(0, 1, 32'h600, 1, 1, 1, 1);
    idle(5, 1);
    cyc(1, 0, 32'h0, 1, 1, 1, 1);
    idle(3, 0);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h700 + 32'(i), 1, 1, 1, 1);
    idle(10, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 9) == 0),
          $urandom() & 32'hffff_fffc,
          ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 9) != 0));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Front-end redirect controller for the Qu core. On a branch mispredict or exception redirect, it flushes the fetch, decode and rename stages and the decode→rename micro-op FIFO. It then loads the new PC and re-enables IF, ID and RN in a staggered order, matching the boot sequence. It sits between the startup sequencer and the front-end stages: every stage enable it drives is the startup enable ANDed with this block's own gate.

## Interface
- PC_WIDTH, 32, redirect/PC width
- FLUSH_CYCLES, 2, cycles flush is held asserted (≥1)
- CNT_WIDTH, 16, redirect statistics counter width

- clk  in  1  core clock
- rst  in  1  reset; one clock, asynchronous, active-high
- if_en_i / id_en_i / rn_en_i  in  1 each  enables from startup sequencer
- redirect_valid  in  1  redirect request, single-cycle pulse or level
- redirect_pc  in  PC_WIDTH  target PC, valid with redirect_valid
- fifo_mp_rn_empty  in  1  micro-op FIFO feeding rename is empty
- if_en / id_en / rn_en  out  1 each  gated stage enables
- if_flush / id_flush / rn_flush / fifo_flush  out  1 each  stage/FIFO flush
- pc_load  out  1  one-cycle PC load strobe
- pc_load_value  out  PC_WIDTH  PC to load
- busy  out  1  redirect sequence in progress (state ≠ RUN)
- redirect_count  out  CNT_WIDTH  accepted redirects, saturating

## Operation
- States: RUN, FLUSH, LOAD, START_IF, START_ID, WAIT_RN. Registered state; Moore outputs.
- **RUN**: all gates 1; flushes 0. redirect_valid → capture redirect_pc, load flush counter with FLUSH_CYCLES−1, go to FLUSH.
- **FLUSH**: all four flushes 1; all gates 0. Counter decrements each cycle. At 0 → LOAD.
- **LOAD**: pc_load=1 and pc_load_value=captured PC; flushes 0; gates 0. → START_IF.
- **START_IF**: IF gate 1. → START_ID.
- **START_ID**: IF and ID gates 1. → WAIT_RN.
- **WAIT_RN**: IF and ID gates 1; RN gate 0 while fifo_mp_rn_empty=1. On the first cycle fifo_mp_rn_empty=0 → RUN (RN gate becomes 1 in RUN).
- **Redirect in any non-RUN state**: recapture PC; reload counter; go to FLUSH. The latest redirect wins; no request is dropped silently.
- **Enable outputs**: if_en = if_en_i & gate_if (same form for ID and RN). While rst=1, all enables are forced to 0.
- **redirect_count**: increments by 1 per cycle in which redirect_valid=1. Holds at 2^CNT_WIDTH−1.
- **Flush counter width**: $clog2(FLUSH_CYCLES+1).
- **Startup gating**: if a startup enable is 0, the matching output stays 0 regardless of state. Sequencing still advances.

## Timing
- Reset values: state RUN; all flushes 0; pc_load 0; pc_load_value 0; redirect_count 0; busy 0; if_en/id_en/rn_en 0.
- Redirect sampled at edge N:
  - flushes high in cycles N+1 … N+FLUSH_CYCLES
  - pc_load in cycle N+FLUSH_CYCLES+1
  - if_en in cycle N+FLUSH_CYCLES+2
  - id_en in cycle N+FLUSH_CYCLES+3
  - rn_en no earlier than N+FLUSH_CYCLES+4
- busy is high from N+1 through the last WAIT_RN cycle.
- Redirect coinciding with pc_load (LOAD state): pc_load still asserts this cycle with the old PC; the next cycle enters FLUSH, which re-flushes the stale fetch.
- Asynchronous rst mid-sequence: immediately returns to RUN with reset output values. The captured PC is cleared.

## Structure
- Shared package (qu_pkg): typedef enum redirect_state_t {RUN, FLUSH, LOAD, START_IF, START_ID, WAIT_RN}, plus the default PC_WIDTH constant.
- One sub-module is natural: sat_counter (parameter WIDTH; inc input; saturating count output), used for redirect_count.
- Flush counter and FSM stay inline.

## Test plan
- **Reset**: rst=1 with all *_en_i=1 → all enables 0, busy 0, redirect_count 0. Release → enables 1 in RUN.
- **Single redirect**: redirect_pc=0x0000_1000 pulse at edge N, FLUSH_CYCLES=2, fifo_mp_rn_empty deasserted at N+6 → flushes high N+1..N+2, pc_load with 0x1000 at N+3, if_en N+4, id_en N+5, rn_en N+7, busy low at N+7, count=1.
- **Redirect during FLUSH**: 0x100 at N, then 0x200 at N+1 → flush window extends to N+3; pc_load at N+4 with 0x200; count=2.
- **Redirect in LOAD**: pc_load asserts with old PC; next cycle flushes reassert; final pc_load carries new PC.
- **Startup gating**: id_en_i=0 through the sequence → id_en stays 0; FSM still reaches RUN.
- **Saturation / reset mid-sequence**: CNT_WIDTH=2, 5 redirects → count=3. Assert rst in WAIT_RN → outputs return to reset values within the same cycle.
